// File: rtl/fadd_norm_ctrl.sv
// rtl/fadd_norm_ctrl.sv - FADD normalization sequencer between mantissa adder and rounding
//
// Takes one unnormalized mantissa/exponent/sign per transaction, asks an
// external leading-zero detector for the shift distance, left-shifts the
// mantissa at most SHIFT_STEP bits per cycle and adjusts the exponent,
// clamping to exponent 0 (subnormal) when the full shift would underflow.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_mant, in_exp, in_sign payload
//   lzd_in              registered mantissa driven to the external LZD
//   lzd_count           LZD result for lzd_in (WIDTH means all-zero)
//   out_valid/out_ready output handshake
//   out_mant, out_exp   normalized mantissa and adjusted exponent
//   out_sign            registered input sign
//   out_zero            input mantissa was zero
//   out_denorm          result clamped to exponent 0

module fadd_norm_ctrl #(
    parameter int WIDTH      = 25,
    parameter int EXP_W      = 8,
    parameter int SHIFT_STEP = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_mant,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic                   in_sign,
    output logic [WIDTH-1:0]       lzd_in,
    input  logic [$clog2(WIDTH):0] lzd_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_mant,
    output logic [EXP_W-1:0]       out_exp,
    output logic                   out_sign,
    output logic                   out_zero,
    output logic                   out_denorm
);

    localparam int LZW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mant;
    logic [EXP_W-1:0] exp_r;
    logic             sign_r;
    logic             zero_r;
    logic             denorm_r;
    logic             valid_r;
    logic [LZW-1:0]   rem;

    logic [EXP_W:0]   lz_ext;
    logic [EXP_W:0]   exp_ext;
    logic             lz_lt_exp;
    logic             all_zero;
    logic [LZW-1:0]   shamt;
    logic [LZW-1:0]   step;

    always_comb begin
        // One extra bit so the lz-vs-exp compare and the subtraction that
        // follows it can never wrap below zero.
        lz_ext    = (EXP_W+1)'(lzd_count);
        exp_ext   = {1'b0, exp_r};
        all_zero  = (lzd_count == LZW'(WIDTH));
        lz_lt_exp = (lz_ext < exp_ext);
        // In the clamp branch exp <= lz <= WIDTH-1, so the low LZW bits of
        // the exponent hold its full value.
        if (lz_lt_exp) begin
            shamt = lzd_count;
        end else if (exp_r == '0) begin
            shamt = '0;
        end else begin
            shamt = exp_r[LZW-1:0] - LZW'(1);
        end
        step = (rem > LZW'(SHIFT_STEP)) ? LZW'(SHIFT_STEP) : rem;
    end

    assign in_ready   = (state == IDLE) && !rst;
    assign lzd_in     = mant;
    assign out_valid  = valid_r;
    assign out_mant   = mant;
    assign out_exp    = exp_r;
    assign out_sign   = sign_r;
    assign out_zero   = zero_r;
    assign out_denorm = denorm_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mant     <= '0;
            exp_r    <= '0;
            sign_r   <= 1'b0;
            zero_r   <= 1'b0;
            denorm_r <= 1'b0;
            valid_r  <= 1'b0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant     <= in_mant;
                        exp_r    <= in_exp;
                        sign_r   <= in_sign;
                        zero_r   <= 1'b0;
                        denorm_r <= 1'b0;
                        state    <= DETECT;
                    end
                end
                DETECT: begin
                    if (all_zero) begin
                        zero_r   <= 1'b1;
                        mant     <= '0;
                        exp_r    <= '0;
                        denorm_r <= 1'b0;
                        rem      <= '0;
                        valid_r  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        if (lz_lt_exp) begin
                            exp_r    <= exp_r - lz_ext[EXP_W-1:0];
                            denorm_r <= 1'b0;
                        end else begin
                            exp_r    <= '0;
                            denorm_r <= 1'b1;
                        end
                        rem <= shamt;
                        if (shamt == '0) begin
                            valid_r <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mant <= mant << step;
                    rem  <= rem - step;
                    // Last step: the remaining distance fits in one shift.
                    if (rem == step) begin
                        valid_r <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_r <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_norm_ctrl.sv
// tb/tb_fadd_norm_ctrl.sv - self-checking bench for fadd_norm_ctrl

module tb_fadd_norm_ctrl;

    localparam int WIDTH = 25;
    localparam int EXP_W = 8;
    localparam int SHIFT_STEP = 8;
    localparam int LZW = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mant;
    logic [EXP_W-1:0] in_exp;
    logic             in_sign;
    logic [WIDTH-1:0] lzd_in;
    logic [LZW-1:0]   lzd_count;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_sign;
    logic             out_zero;
    logic             out_denorm;

    fadd_norm_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W), .SHIFT_STEP(SHIFT_STEP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
        .lzd_in(lzd_in), .lzd_count(lzd_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    // External leading-zero detector: last assignment wins = highest set bit.
    function automatic logic [LZW-1:0] lzc(input logic [WIDTH-1:0] m);
        logic [LZW-1:0] r;
        r = LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) if (m[i]) r = LZW'(WIDTH - 1 - i);
        return r;
    endfunction
    assign lzd_count = lzc(lzd_in);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: normalization computed from the arithmetic rules.
    logic             pending = 1'b0;
    logic [WIDTH-1:0] m_mant;
    logic [EXP_W-1:0] m_exp;
    logic             m_sign, m_zero, m_denorm;
    int               m_lat;

    task automatic model(input logic [WIDTH-1:0] mant, input logic [EXP_W-1:0] e, input logic s);
        int mi, lz, sh, ei;
        mi = int'(mant);
        ei = int'(e);
        m_sign = s;
        sh = 0;
        if (mi == 0) begin
            m_zero = 1'b1; m_mant = '0; m_exp = '0; m_denorm = 1'b0;
        end else begin
            m_zero = 1'b0;
            lz = WIDTH - $clog2(mi + 1);
            if (lz < ei) begin
                sh = lz; m_exp = EXP_W'(ei - lz); m_denorm = 1'b0;
            end else begin
                sh = (ei == 0) ? 0 : ei - 1; m_exp = '0; m_denorm = 1'b1;
            end
            m_mant = WIDTH'(mi << sh);
        end
        m_lat = 2 + (sh + SHIFT_STEP - 1) / SHIFT_STEP;
    endtask

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!pending) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("cmp_mant", 32'(out_mant), 32'(m_mant));
                chk("cmp_exp", 32'(out_exp), 32'(m_exp));
                chk("cmp_sign", 32'(out_sign), 32'(m_sign));
                chk("cmp_zero", 32'(out_zero), 32'(m_zero));
                chk("cmp_denorm", 32'(out_denorm), 32'(m_denorm));
            end
        end
    end

    task automatic accept(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e, input logic s);
        @(negedge clk);
        in_mant = m; in_exp = e; in_sign = s; in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        model(m, e, s);
        @(posedge clk);
        pending = 1'b1;
    endtask

    // Waits for out_valid (bounded); hold_in keeps in_valid high with other data.
    task automatic wait_valid(input string name, input int lat_req, input bit hold_in);
        int cyc;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (hold_in) begin
                in_mant = 25'h0000001; in_exp = 8'd10;
            end else begin
                in_valid = 1'b0;
            end
            chk({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            if (out_valid) break;
        end
        chk({name, "_latency"}, 32'(cyc), 32'(lat_req));
        chk({name, "_model_latency"}, 32'(m_lat), 32'(lat_req));
    endtask

    task automatic complete(input string name);
        @(posedge clk);
        pending = 1'b0;
        @(negedge clk);
        chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic pin(input string name, input logic [WIDTH-1:0] mant, input logic [EXP_W-1:0] e,
                       input logic z, input logic d);
        chk({name, "_lit_mant"}, 32'(out_mant), 32'(mant));
        chk({name, "_lit_exp"}, 32'(out_exp), 32'(e));
        chk({name, "_lit_zero"}, 32'(out_zero), 32'(z));
        chk({name, "_lit_denorm"}, 32'(out_denorm), 32'(d));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outputs", 32'({out_mant, out_exp, out_sign, out_zero, out_denorm}), 32'd0);
        rst = 1'b0;

        // Case 1: already normalized.
        accept(25'h1000000, 8'd100, 1'b1);
        wait_valid("c1", 2, 1'b0);
        pin("c1", 25'h1000000, 8'd100, 1'b0, 1'b0);
        chk("c1_lit_sign", 32'(out_sign), 32'd1);
        complete("c1");

        // Case 2: lz=13, shifts of 8 then 5.
        accept(25'h0000800, 8'd100, 1'b0);
        wait_valid("c2", 4, 1'b0);
        pin("c2", 25'h1000000, 8'd87, 1'b0, 1'b0);
        complete("c2");

        // Case 3: denormal clamp, shamt=9.
        accept(25'h0000001, 8'd10, 1'b0);
        wait_valid("c3", 4, 1'b0);
        pin("c3", 25'h0000200, 8'd0, 1'b0, 1'b1);
        complete("c3");

        // Case 4: zero mantissa.
        accept(25'h0000000, 8'd55, 1'b1);
        wait_valid("c4", 2, 1'b0);
        pin("c4", 25'h0000000, 8'd0, 1'b1, 1'b0);
        complete("c4");

        // Boundaries: exactly one step, lz==exp, lz==exp-1, exp==0.
        accept(25'h0010000, 8'd100, 1'b0);
        wait_valid("step8", 3, 1'b0);
        pin("step8", 25'h1000000, 8'd92, 1'b0, 1'b0);
        complete("step8");

        accept(25'h0000800, 8'd13, 1'b0);
        wait_valid("lz_eq_exp", 4, 1'b0);
        pin("lz_eq_exp", 25'h0800000, 8'd0, 1'b0, 1'b1);
        complete("lz_eq_exp");

        accept(25'h0000800, 8'd14, 1'b1);
        wait_valid("lz_lt_exp", 4, 1'b0);
        pin("lz_lt_exp", 25'h1000000, 8'd1, 1'b0, 1'b0);
        complete("lz_lt_exp");

        accept(25'h0000001, 8'd0, 1'b0);
        wait_valid("exp0", 2, 1'b0);
        pin("exp0", 25'h0000001, 8'd0, 1'b0, 1'b1);
        complete("exp0");

        // Back-pressure with in_valid held high.
        out_ready = 1'b0;
        accept(25'h0000800, 8'd100, 1'b1);
        wait_valid("stall", 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        pin("stall", 25'h1000000, 8'd87, 1'b0, 1'b0);
        out_ready = 1'b1;
        in_valid = 1'b0;
        complete("stall");

        // Reset in the first SHIFT cycle of case 2.
        accept(25'h0000800, 8'd100, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pending = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_outputs", 32'({out_mant, out_exp, out_sign, out_zero, out_denorm}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end

        accept(25'h1000000, 8'd100, 1'b1);
        wait_valid("post_rst", 2, 1'b0);
        pin("post_rst", 25'h1000000, 8'd100, 1'b0, 1'b0);
        complete("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
